// File: rtl/sonic_sync_ring_gearbox.sv
// Single-clock ring buffer gearbox: wide DMA words in, OUT_WIDTH slices out
// (least-significant first), with flow control, occupancy, flush and error flags.
module sonic_sync_ring_gearbox #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 2,
  parameter int DEPTH     = 512
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [IN_WIDTH-1:0]    wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [OUT_WIDTH-1:0]   rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] fill_words,
  output logic                   overflow,
  output logic                   underrun
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int SW    = $clog2(RATIO);

  logic [IN_WIDTH-1:0] ring_mem [DEPTH];

  logic [PW-1:0]       wr_ptr_reg;
  logic [PW-1:0]       rd_ptr_reg;
  logic [PW-1:0]       fill_next;
  logic [IN_WIDTH-1:0] pf_data_reg;
  logic                pf_valid_reg;
  logic [IN_WIDTH-1:0] hold_reg;
  logic [SW-1:0]       slice_reg;
  logic                rd_valid_reg;
  logic                wr_ready_reg;
  logic                primed_reg;
  logic                overflow_reg;
  logic                underrun_reg;

  logic wr_accept;
  logic rd_xfer;
  logic last_slice;
  logic hold_load;
  logic fetch;

  logic [RATIO-1:0][OUT_WIDTH-1:0] hold_lanes;
  logic [RATIO-1:0][OUT_WIDTH-1:0] hold_shifted;

  assign hold_lanes = hold_reg;

  // Each lane takes the next-higher lane; the top lane fills with zeros.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      if (gi < RATIO - 1) begin : g_mid
        assign hold_shifted[gi] = hold_lanes[gi+1];
      end else begin : g_top
        assign hold_shifted[gi] = '0;
      end
    end
  endgenerate

  assign wr_ready   = wr_ready_reg && !flush;
  assign wr_accept  = wr_valid && wr_ready;
  assign rd_xfer    = rd_valid_reg && rd_ready;
  assign last_slice = (slice_reg == SW'(RATIO - 1));
  assign fill_words = wr_ptr_reg - rd_ptr_reg;
  assign fetch      = !flush && !pf_valid_reg && (fill_words != '0);
  assign hold_load  = pf_valid_reg && (!rd_valid_reg || (rd_xfer && last_slice));
  assign fill_next  = fill_words + PW'(wr_accept) - PW'(fetch);

  assign rd_data  = hold_reg[OUT_WIDTH-1:0];
  assign rd_valid = rd_valid_reg;
  assign overflow = overflow_reg;
  assign underrun = underrun_reg;

  // Ring storage with registered read straight into the prefetch register.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      ring_mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
    if (fetch) begin
      pf_data_reg <= ring_mem[rd_ptr_reg[AW-1:0]];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pf_valid_reg <= 1'b0;
      hold_reg     <= '0;
      slice_reg    <= '0;
      rd_valid_reg <= 1'b0;
      wr_ready_reg <= 1'b0;
      primed_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pf_valid_reg <= 1'b0;
      hold_reg     <= '0;
      slice_reg    <= '0;
      rd_valid_reg <= 1'b0;
      wr_ready_reg <= 1'b0;
      primed_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (fetch) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      // Ready tracks the post-edge count and holds the last RAM slot back,
      // so a registered ready can never let a write land on unread data.
      wr_ready_reg <= (fill_next < PW'(DEPTH - 1));

      if (fetch) begin
        pf_valid_reg <= 1'b1;
      end else if (hold_load) begin
        pf_valid_reg <= 1'b0;
      end

      if (hold_load) begin
        hold_reg     <= pf_data_reg;
        slice_reg    <= '0;
        rd_valid_reg <= 1'b1;
      end else if (rd_xfer) begin
        hold_reg  <= hold_shifted;
        slice_reg <= slice_reg + 1'b1;
        if (last_slice) begin
          rd_valid_reg <= 1'b0;
        end
      end

      primed_reg <= primed_reg || rd_xfer;

      if (wr_valid && !wr_ready) begin
        overflow_reg <= 1'b1;
      end
      if (rd_ready && !rd_valid_reg && primed_reg) begin
        underrun_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sonic_sync_ring_gearbox.sv
// Scoreboard bench for sonic_sync_ring_gearbox: a slice queue fed on every
// accepted write and drained by a monitor on every delivered slice.
module tb_sonic_sync_ring_gearbox;

  localparam int IN_W  = 128;
  localparam int OUT_W = 2;
  localparam int DEPTH = 16;
  localparam int RATIO = IN_W / OUT_W;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic             clock    = 1'b0;
  logic             reset    = 1'b1;
  logic             flush    = 1'b0;
  logic             wr_valid = 1'b0;
  logic             rd_ready = 1'b0;
  logic [IN_W-1:0]  wr_data  = '0;
  logic             wr_ready;
  logic             rd_valid;
  logic             overflow;
  logic             underrun;
  logic [OUT_W-1:0] rd_data;
  logic [FW-1:0]    fill_words;

  int tests     = 0;
  int fails     = 0;
  int delivered = 0;
  int words_in  = 0;

  logic [OUT_W-1:0] sb[$];
  logic             hold_seen = 1'b0;
  logic [OUT_W-1:0] hold_val  = '0;

  bit track   = 1'b0;
  bit started = 1'b0;
  int gaps    = 0;
  int base    = 0;
  int total   = 0;

  sonic_sync_ring_gearbox #(
    .IN_WIDTH (IN_W),
    .OUT_WIDTH(OUT_W),
    .DEPTH    (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .fill_words(fill_words),
    .overflow  (overflow),
    .underrun  (underrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the ring model is just an ordered list of slices still owed.
  always @(negedge clock) begin
    if (reset || flush) begin
      sb.delete();
      hold_seen = 1'b0;
    end else begin
      if (wr_valid && wr_ready) begin
        for (int k = 0; k < RATIO; k++) sb.push_back(wr_data[k*OUT_W +: OUT_W]);
        words_in++;
        $display("[TB] WR word %0d data=%h fill=%0d", words_in, wr_data, fill_words);
      end
      if (hold_seen && rd_valid) check("rd_data_stable", rd_data, hold_val);
      hold_seen = 1'b0;
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL rd_slice: got %0h, expected no slice (scoreboard empty)", rd_data);
        end else begin
          check("rd_slice", rd_data, sb.pop_front());
        end
        delivered++;
        if (delivered % RATIO == 0) $display("[TB] RD %0d slices delivered", delivered);
      end else if (rd_valid) begin
        hold_seen = 1'b1;
        hold_val  = rd_data;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (track) begin
      if (rd_valid) started = 1'b1;
      else if (started && (delivered - base) < total) gaps++;
    end
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask

  task automatic send(input logic [IN_W-1:0] d);
    logic a;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      a = wr_ready;
      tick();
      if (a) begin
        wr_valid = 1'b0;
        return;
      end
    end
    wr_valid = 1'b0;
    tests++;
    fails++;
    $display("[TB] FAIL send_timeout: got no accept, expected wr_ready within 400 cycles");
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && !rd_valid; i++) tick();
    check(name, rd_valid, 1);
  endtask

  task automatic drain(input string name, input int budget);
    rd_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !rd_valid) break;
      tick();
    end
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_rd_idle"}, rd_valid, 0);
  endtask

  // Entered with reset asserted; releases it between edges and runs one word.
  task automatic single_word();
    logic [IN_W-1:0] w;
    int b;
    w = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_fill", fill_words, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underrun", underrun, 0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    tick();
    check("wr_ready_rise", wr_ready, 1);
    b = delivered;
    wr_data  = w;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("lat_e0_valid", rd_valid, 0);
    check("lat_e0_fill", fill_words, 1);
    tick();
    check("lat_e1_valid", rd_valid, 0);
    check("lat_e1_fill", fill_words, 0);
    tick();
    check("lat_e2_valid", rd_valid, 1);
    check("first_slice", rd_data, w[1:0]);
    for (int i = 0; i < 4 * RATIO && rd_valid; i++) tick();
    check("single_slices", delivered - b, RATIO);
    check("single_rd_drop", rd_valid, 0);
    check("underrun_pre", underrun, 0);
    tick();
    check("underrun_set", underrun, 1);
  endtask

  initial begin
    int acc;
    int cyc;
    int nw;
    logic a;
    logic [IN_W-1:0] wa;
    logic [IN_W-1:0] wb;

    repeat (3) @(posedge clock);
    #1;

    // Single word from reset
    single_word();

    // Fill to the limit with the consumer stalled, then overflow and drain
    flush_pulse();
    rd_ready = 1'b0;
    base     = delivered;
    acc      = 0;
    cyc      = 0;
    wr_valid = 1'b1;
    while (acc < DEPTH + 1 && cyc < 400) begin
      wr_data = {4{32'(acc + 1)}};
      @(negedge clock);
      a = wr_ready;
      tick();
      cyc++;
      if (a) acc++;
    end
    check("fill_accepts", acc, DEPTH + 1);
    check("fill_wr_ready_low", wr_ready, 0);
    check("fill_words_max", fill_words, DEPTH - 1);
    check("fill_no_overflow_yet", overflow, 0);
    wr_data = {4{32'hDEAD_BEEF}};
    tick();
    wr_valid = 1'b0;
    check("overflow_set", overflow, 1);
    check("fill_after_overflow", fill_words, DEPTH - 1);
    check("fill_no_underrun", underrun, 0);
    drain("fill_drain", (DEPTH + 3) * RATIO);
    check("fill_drained_slices", delivered - base, (DEPTH + 1) * RATIO);
    check("fill_wr_ready_back", wr_ready, 1);
    check("fill_empty", fill_words, 0);

    // Paced streaming across both pointer wraps
    flush_pulse();
    rd_ready = 1'b1;
    base     = delivered;
    total    = 3 * DEPTH * RATIO;
    gaps     = 0;
    started  = 1'b0;
    track    = 1'b1;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      send({$urandom, $urandom, $urandom, $urandom});
      if (k > 0) repeat (RATIO - 1) tick();
    end
    for (int i = 0; i < 4 * RATIO && (delivered - base) < total; i++) tick();
    track = 1'b0;
    check("wrap_slices", delivered - base, total);
    check("wrap_started", started, 1);
    check("wrap_no_bubble", gaps, 0);
    check("wrap_sb_empty", sb.size(), 0);

    // Random backpressure
    flush_pulse();
    base = delivered;
    nw   = 0;
    for (int c = 0; c < 1500; c++) begin
      rd_ready = ($urandom_range(0, 99) < 55);
      if (!wr_valid && $urandom_range(0, 59) == 0) begin
        wr_data  = {$urandom, $urandom, $urandom, $urandom};
        wr_valid = 1'b1;
        nw++;
      end
      @(negedge clock);
      a = wr_valid && wr_ready;
      tick();
      if (a) wr_valid = 1'b0;
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 2000 && wr_valid; i++) begin
      @(negedge clock);
      a = wr_ready;
      tick();
      if (a) wr_valid = 1'b0;
    end
    wr_valid = 1'b0;
    drain("bp_drain", (DEPTH + 4) * RATIO);
    check("bp_slices", delivered - base, nw * RATIO);
    tick();
    check("bp_underrun", underrun, 1);

    // Flush in the middle of a word, with a write presented alongside
    rd_ready = 1'b0;
    wa = {$urandom, $urandom, $urandom, $urandom};
    send(wa);
    wait_valid("flushmid_a_valid", 10);
    rd_ready = 1'b1;
    repeat (10) tick();
    rd_ready = 1'b0;
    check("flushmid_slices_left", sb.size(), RATIO - 10);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = ~wa;
    @(negedge clock);
    check("flush_wr_ready_low", wr_ready, 0);
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    check("flush_rd_valid", rd_valid, 0);
    check("flush_fill", fill_words, 0);
    check("flush_overflow", overflow, 0);
    check("flush_underrun", underrun, 0);
    check("flush_rd_data", rd_data, 0);
    tick();
    check("flush_wr_ready_back", wr_ready, 1);
    base = delivered;
    wb   = {$urandom, $urandom, $urandom, $urandom};
    send(wb);
    wait_valid("flushmid_b_valid", 10);
    check("flushmid_b_slice0", rd_data, wb[1:0]);
    drain("flushmid_b_drain", 3 * RATIO);
    check("flushmid_b_slices", delivered - base, RATIO);
    check("flushmid_fill", fill_words, 0);

    // Asynchronous reset in the middle of a stream
    rd_ready = 1'b1;
    send('1);
    send({$urandom, $urandom, $urandom, $urandom});
    send({$urandom, $urandom, $urandom, $urandom});
    repeat (3) tick();
    check("pre_rst_valid", rd_valid, 1);
    check("pre_rst_data", rd_data, 3);
    check("pre_rst_fill", fill_words, 1);
    check("pre_rst_underrun", underrun, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_wr_ready", wr_ready, 0);
    check("async_rd_valid", rd_valid, 0);
    check("async_rd_data", rd_data, 0);
    check("async_fill", fill_words, 0);
    check("async_overflow", overflow, 0);
    check("async_underrun", underrun, 0);
    tick();
    tick();
    single_word();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
